// File: rtl/snake_pkg.sv
// Shared encodings for the snake direction input block: heading codes,
// button channel indices and the reversal helper.
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;

   // Encodings are arranged so the opposite heading differs only in bit 1.
   function automatic logic [1:0] dir_opposite(input logic [1:0] d);
      return d ^ 2'd2;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: polarity fix, 2-FF synchroniser, hold-time debounce
// counter and registered press/release pulses aligned with the level change.
module btn_debounce #(
   parameter int DEB_CYCLES = 250000,
   parameter int CNT_W      = 18,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic clock,
   input  logic resetn,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      cnt_d     = '0;
      // Any cycle where the synchronised input agrees with the level restarts the count.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d   = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= raw_i ^ ACTIVE_LOW;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         cnt_q     <= cnt_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/snake_dir_input.sv
// Button debouncer array plus the snake heading register: direction presses
// are latched as a pending request and applied only on the game tick.
module snake_dir_input
   import snake_pkg::*;
#(
   parameter int         NUM_BTN    = 4,
   parameter int         DEB_CYCLES = 250000,
   parameter int         CNT_W      = 18,
   parameter bit         ACTIVE_LOW = 1'b0,
   parameter logic [1:0] INIT_DIR   = 2'd1
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic               enable,
   input  logic               tick,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [1:0]         dir,
   output logic               dir_changed,
   output logic               dir_rejected
);

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
      btn_debounce #(
         .DEB_CYCLES (DEB_CYCLES),
         .CNT_W      (CNT_W),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_deb (
         .clock     (clock),
         .resetn    (resetn),
         .raw_i     (btn_raw[gi]),
         .level_o   (btn_level[gi]),
         .press_o   (btn_press[gi]),
         .release_o (btn_release[gi])
      );
   end

   logic [1:0] dir_q, dir_d;
   logic [1:0] pend_dir_q, pend_dir_d;
   logic       pend_vld_q, pend_vld_d;
   logic       changed_q, changed_d;
   logic       rejected_q, rejected_d;
   logic       sel_vld, req_vld;
   logic [1:0] sel_dir, req_dir;

   always_comb begin
      sel_vld = |btn_press[3:0];
      if (btn_press[BTN_UP])        sel_dir = DIR_UP;
      else if (btn_press[BTN_DOWN]) sel_dir = DIR_DOWN;
      else if (btn_press[BTN_LEFT]) sel_dir = DIR_LEFT;
      else                          sel_dir = DIR_RIGHT;
      req_vld = sel_vld | pend_vld_q;
      req_dir = sel_vld ? sel_dir : pend_dir_q;
   end

   always_comb begin
      dir_d      = dir_q;
      pend_dir_d = pend_dir_q;
      pend_vld_d = pend_vld_q;
      changed_d  = 1'b0;
      rejected_d = 1'b0;
      if (!enable) begin
         pend_vld_d = 1'b0;
      end else if (tick) begin
         // Reversal is judged against the heading in effect at this tick.
         pend_vld_d = 1'b0;
         if (req_vld) begin
            if (req_dir == dir_opposite(dir_q)) begin
               rejected_d = 1'b1;
            end else if (req_dir != dir_q) begin
               dir_d     = req_dir;
               changed_d = 1'b1;
            end
         end
      end else if (sel_vld) begin
         pend_vld_d = 1'b1;
         pend_dir_d = sel_dir;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dir_q      <= INIT_DIR;
         pend_dir_q <= DIR_UP;
         pend_vld_q <= 1'b0;
         changed_q  <= 1'b0;
         rejected_q <= 1'b0;
      end else begin
         dir_q      <= dir_d;
         pend_dir_q <= pend_dir_d;
         pend_vld_q <= pend_vld_d;
         changed_q  <= changed_d;
         rejected_q <= rejected_d;
      end
   end

   assign dir          = dir_q;
   assign dir_changed  = changed_q;
   assign dir_rejected = rejected_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// Bench for snake_dir_input with short debounce; a negedge monitor pops every
// pulse event against the expected queue filled by the driver tasks.
module tb_snake_dir_input;

   localparam int NB = 5;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic [NB-1:0] btn_raw = '0;
   logic          enable = 1'b1;
   logic          tick = 1'b0;
   logic [NB-1:0] btn_level, btn_press, btn_release;
   logic [1:0]    dir;
   logic          dir_changed, dir_rejected;

   logic [7:0] exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic       mon_en = 1'b0;

   snake_dir_input #(
      .NUM_BTN    (NB),
      .DEB_CYCLES (8),
      .CNT_W      (4),
      .ACTIVE_LOW (1'b0),
      .INIT_DIR   (2'd1)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .btn_raw      (btn_raw),
      .enable       (enable),
      .tick         (tick),
      .btn_level    (btn_level),
      .btn_press    (btn_press),
      .btn_release  (btn_release),
      .dir          (dir),
      .dir_changed  (dir_changed),
      .dir_rejected (dir_rejected)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Event codes: kind 1 press, 2 dir_changed, 3 dir_rejected, 4 release.
   task automatic mon_event(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      if (exp_q.size() == 0) e = 8'hff;
      else e = exp_q.pop_front();
      check(tag, {24'd0, obs}, {24'd0, e});
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         if (|btn_press)   mon_event("press_evt", {3'd1, btn_press});
         if (|btn_release) mon_event("release_evt", {3'd4, btn_release});
         if (dir_changed)  mon_event("changed_evt", {3'd2, 3'd0, dir});
         if (dir_rejected) mon_event("rejected_evt", {3'd3, 3'd0, dir});
      end
   end

   task automatic do_reset();
      @(posedge clock);
      #1 resetn = 1'b0;
      btn_raw = '0;
      tick = 1'b0;
      @(negedge clock);
      check("rst_dir", {30'd0, dir}, 32'd1);
      check("rst_level", {27'd0, btn_level}, 32'd0);
      check("rst_press", {27'd0, btn_press}, 32'd0);
      check("rst_release", {27'd0, btn_release}, 32'd0);
      check("rst_changed", {31'd0, dir_changed}, 32'd0);
      check("rst_rejected", {31'd0, dir_rejected}, 32'd0);
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   // Clean press: pulse is due exactly 2+DEB_CYCLES clocks after the raw edge.
   task automatic tap(input logic [NB-1:0] mask);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      @(posedge clock);
      #1 btn_raw = btn_raw | mask;
      repeat (10) @(negedge clock);
      check("tap_level_early", {27'd0, btn_level & mask}, 32'd0);
      #1 exp_q.push_back({3'd1, mask});
      @(negedge clock);
      check("tap_level", {27'd0, btn_level & mask}, {27'd0, mask});
   endtask

   task automatic untap(input logic [NB-1:0] mask);
      @(posedge clock);
      #1 btn_raw = btn_raw & ~mask;
      repeat (10) @(negedge clock);
      #1 exp_q.push_back({3'd4, mask});
      @(negedge clock);
      check("untap_level", {27'd0, btn_level & mask}, 32'd0);
   endtask

   // kind 0 = no event expected, 2 = change to d, 3 = rejection with dir d.
   task automatic do_tick(input logic [2:0] kind, input logic [1:0] d);
      @(posedge clock);
      #1 tick = 1'b1;
      if (kind != 3'd0) exp_q.push_back({kind, 3'd0, d});
      @(posedge clock);
      #1 tick = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      // 1: reset, then reset again in the middle of a debounce count
      do_reset();
      mon_en = 1'b1;
      @(posedge clock);
      #1 btn_raw[0] = 1'b1;
      repeat (6) @(posedge clock);
      do_reset();
      repeat (14) @(negedge clock);
      check("midrst_level", {27'd0, btn_level}, 32'd0);

      // 2: bouncing input; single press 10 clocks after the final rise
      @(posedge clock);
      #1 btn_raw[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         repeat (3) @(posedge clock);
         #1 btn_raw[0] = ~btn_raw[0];
      end
      repeat (10) @(negedge clock);
      check("bounce_level_early", {31'd0, btn_level[0]}, 32'd0);
      #1 exp_q.push_back({3'd1, 5'b00001});
      @(negedge clock);
      check("bounce_press", {27'd0, btn_press}, 32'h1);
      check("bounce_level", {31'd0, btn_level[0]}, 32'd1);
      untap(5'b00001);
      do_reset();

      // 3: UP from RIGHT is applied; a bare tick afterwards does nothing
      tap(5'b00001);
      untap(5'b00001);
      do_tick(3'd2, 2'd0);
      check("t3_dir", {30'd0, dir}, 32'd0);
      do_tick(3'd0, 2'd0);
      check("t3_dir_hold", {30'd0, dir}, 32'd0);

      // pending request discarded by reset
      tap(5'b00100);
      untap(5'b00100);
      do_reset();
      do_tick(3'd0, 2'd0);
      check("rst_pend_dir", {30'd0, dir}, 32'd1);

      // 4: reversal rejected; latest of two presses wins and is rejected
      tap(5'b00100);
      untap(5'b00100);
      do_tick(3'd3, 2'd1);
      check("t4_dir", {30'd0, dir}, 32'd1);
      tap(5'b00001);
      untap(5'b00001);
      tap(5'b00100);
      untap(5'b00100);
      do_tick(3'd3, 2'd1);
      check("t4_latest_dir", {30'd0, dir}, 32'd1);

      // 5: simultaneous UP+DOWN -> UP; press in the tick cycle applies at once
      tap(5'b00011);
      untap(5'b00011);
      do_tick(3'd2, 2'd0);
      check("t5_prio_dir", {30'd0, dir}, 32'd0);
      @(posedge clock);
      #1 btn_raw[3] = 1'b1;
      exp_q.push_back({3'd1, 5'b01000});
      exp_q.push_back({3'd2, 3'd0, 2'd1});
      repeat (10) @(posedge clock);
      #1 tick = 1'b1;
      @(posedge clock);
      #1 tick = 1'b0;
      @(negedge clock);
      check("t5_sametick_dir", {30'd0, dir}, 32'd1);
      untap(5'b01000);
      do_tick(3'd0, 2'd0);
      check("t5_pend_clr", {30'd0, dir}, 32'd1);

      // 6: enable low ignores presses and clears a pending request
      enable = 1'b0;
      tap(5'b00010);
      untap(5'b00010);
      do_tick(3'd0, 2'd0);
      check("t6_dis_dir", {30'd0, dir}, 32'd1);
      enable = 1'b1;
      do_tick(3'd0, 2'd0);
      check("t6_en_dir", {30'd0, dir}, 32'd1);
      tap(5'b00010);
      untap(5'b00010);
      @(posedge clock);
      #1 enable = 1'b0;
      @(posedge clock);
      #1 enable = 1'b1;
      do_tick(3'd0, 2'd0);
      check("t6_clr_dir", {30'd0, dir}, 32'd1);
      tap(5'b00010);
      untap(5'b00010);
      do_tick(3'd2, 2'd2);
      check("t6_down_dir", {30'd0, dir}, 32'd2);
      tap(5'b10000);
      untap(5'b10000);
      do_tick(3'd0, 2'd0);
      check("t6_ch4_dir", {30'd0, dir}, 32'd2);

      repeat (3) @(negedge clock);
      check("q_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
